game_menu_renderer_block: RTL and testbench

GAME_MENU_RENDERER_BLOCK -- requirements
Module: game_menu_renderer

---
 rtl/game_menu_renderer_block_if.sv | 23 ++
 rtl/game_menu_renderer_block.sv | 112 +++++++++++
 tb/tb_game_menu_renderer_block.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/game_menu_renderer_block_if.sv
// Pixel-query bus for the game menu renderer: frame tick, scene geometry,
// queried pixel coordinate and the resulting colour.
interface game_menu_renderer_block_if;
  logic       frameClk;
  logic [7:0] dinoY;
  logic [7:0] obs1X;
  logic [7:0] obs1H;
  logic [7:0] obs2X;
  logic [7:0] obs2H;
  logic [7:0] x;
  logic [7:0] y;
  logic [2:0] color;

  modport master (
    output frameClk, dinoY, obs1X, obs1H, obs2X, obs2H, x, y,
    input  color
  );

  modport slave (
    input  frameClk, dinoY, obs1X, obs1H, obs2X, obs2H, x, y,
    output color
  );
endinterface

// File: rtl/game_menu_renderer_block.sv
// Combinational pixel colour lookup for the dino scene with a fixed overlay
// (menu, pause or game over) and a frame counter that drives the menu blink.
module game_menu_renderer_block #(
  parameter int unsigned SCREEN     = 0,
  parameter int unsigned XMAX       = 159,
  parameter int unsigned YMAX       = 119,
  parameter int unsigned GROUND_TOP = 100,
  parameter int unsigned DINO_X     = 10,
  parameter int unsigned DINO_W     = 10,
  parameter int unsigned DINO_H     = 12,
  parameter int unsigned OBS_W      = 6,
  parameter int unsigned BLINK_BIT  = 4
) (
  input logic                         clk,
  input logic                         resetn,
  game_menu_renderer_block_if.slave   bus
);

  localparam logic [2:0] BG    = 3'b111;
  localparam logic [2:0] FG    = 3'b000;
  localparam logic [2:0] MENU  = 3'b110;
  localparam logic [2:0] PAUSE = 3'b001;
  localparam logic [2:0] OVER  = 3'b100;

  localparam logic [8:0] XMAX9 = 9'(XMAX);
  localparam logic [8:0] YMAX9 = 9'(YMAX);
  localparam logic [8:0] GT9   = 9'(GROUND_TOP);
  localparam logic [8:0] DX9   = 9'(DINO_X);
  localparam logic [8:0] DW9   = 9'(DINO_W);
  localparam logic [8:0] DH9   = 9'(DINO_H);
  localparam logic [8:0] OW9   = 9'(OBS_W);

  typedef enum logic [1:0] {SCR_MENU, SCR_PAUSE, SCR_OVER} screen_e;
  localparam screen_e MODE = (SCREEN == 1) ? SCR_PAUSE :
                             (SCREEN == 2) ? SCR_OVER  : SCR_MENU;

  logic [7:0] frameCnt;
  logic       blink;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)           frameCnt <= '0;
    else if (bus.frameClk) frameCnt <= frameCnt + 8'd1;
  end

  assign blink = frameCnt[BLINK_BIT];

  // Obstacle top is GROUND_TOP-h, which goes negative for tall obstacles,
  // so the row test is signed in 9 bits.
  function automatic logic obsHit(input logic [7:0] ox, input logic [7:0] oh,
                                  input logic [8:0] qx, input logic [8:0] qy);
    logic signed [8:0] top;
    top = $signed(GT9) - $signed({1'b0, oh});
    return (oh != 8'd0) && (qx >= {1'b0, ox}) && (qx < {1'b0, ox} + OW9) &&
           ($signed(qy) >= top) && (qy < GT9);
  endfunction

  logic [8:0]        px, py;
  logic              offScreen, onGround, onDino, onObs;
  logic              inPanel, panelEdge, inStart, inBars, inSquare, onCross;
  logic signed [8:0] diff;
  logic [8:0]        sum;
  logic              ovlHit;
  logic [2:0]        ovlColor;
  logic [2:0]        colorNext;

  always_comb begin
    px        = {1'b0, bus.x};
    py        = {1'b0, bus.y};
    offScreen = (px > XMAX9) || (py > YMAX9);
    onGround  = (py >= GT9) && (py <= GT9 + 9'd1);
    onDino    = (px >= DX9) && (px < DX9 + DW9) &&
                (py >= {1'b0, bus.dinoY}) && (py < {1'b0, bus.dinoY} + DH9);
    onObs     = obsHit(bus.obs1X, bus.obs1H, px, py) ||
                obsHit(bus.obs2X, bus.obs2H, px, py);

    inPanel   = (px >= 9'd40) && (px <= 9'd119) && (py >= 9'd30) && (py <= 9'd69);
    panelEdge = (px == 9'd40) || (px == 9'd119) || (py == 9'd30) || (py == 9'd69);
    inStart   = (px >= 9'd60) && (px <= 9'd99) && (py >= 9'd46) && (py <= 9'd53);
    inBars    = (((px >= 9'd68) && (px <= 9'd75)) || ((px >= 9'd84) && (px <= 9'd91))) &&
                (py >= 9'd35) && (py <= 9'd64);
    inSquare  = inPanel && (px >= 9'd60) && (px <= 9'd99);
    diff      = $signed(px - 9'd60) - $signed(py - 9'd30);
    sum       = (px - 9'd60) + (py - 9'd30);
    onCross   = inSquare && ((diff == 9'sd0) || (diff == 9'sd1) ||
                             (sum == 9'd39) || (sum == 9'd40));

    ovlHit   = 1'b0;
    ovlColor = BG;
    case (MODE)
      SCR_PAUSE: begin
        ovlHit   = inBars;
        ovlColor = PAUSE;
      end
      SCR_OVER: begin
        ovlHit   = inPanel;
        ovlColor = (panelEdge || onCross) ? FG : OVER;
      end
      default: begin
        ovlHit   = inPanel;
        ovlColor = (panelEdge || (inStart && blink)) ? FG : MENU;
      end
    endcase

    if (offScreen)                        colorNext = BG;
    else if (ovlHit)                      colorNext = ovlColor;
    else if (onDino || onObs || onGround) colorNext = FG;
    else                                  colorNext = BG;
  end

  assign bus.color = colorNext;

endmodule

// File: tb/tb_game_menu_renderer_block.sv
// Directed bench for game_menu_renderer_block: one instance per overlay mode,
// a vector table for static pixels plus blink, wrap and reset sequences.
module tb_game_menu_renderer_block;

  logic clk = 1'b0;
  logic resetn;

  game_menu_renderer_block_if if0 ();
  game_menu_renderer_block_if if1 ();
  game_menu_renderer_block_if if2 ();
  game_menu_renderer_block_if if3 ();

  game_menu_renderer_block #(.SCREEN(0)) dut0 (.clk(clk), .resetn(resetn), .bus(if0.slave));
  game_menu_renderer_block #(.SCREEN(1)) dut1 (.clk(clk), .resetn(resetn), .bus(if1.slave));
  game_menu_renderer_block #(.SCREEN(2)) dut2 (.clk(clk), .resetn(resetn), .bus(if2.slave));
  game_menu_renderer_block #(.SCREEN(3)) dut3 (.clk(clk), .resetn(resetn), .bus(if3.slave));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned scr;
    logic [7:0]  dy, o1x, o1h, o2x, o2h, px, py;
    logic [2:0]  exp;
  } vec_t;

  vec_t vecs[$];
  int   vecCount = 0;
  int   errCount = 0;

  task automatic setIn(input logic [7:0] dy, o1x, o1h, o2x, o2h, px, py);
    if0.dinoY = dy; if0.obs1X = o1x; if0.obs1H = o1h; if0.obs2X = o2x; if0.obs2H = o2h; if0.x = px; if0.y = py;
    if1.dinoY = dy; if1.obs1X = o1x; if1.obs1H = o1h; if1.obs2X = o2x; if1.obs2H = o2h; if1.x = px; if1.y = py;
    if2.dinoY = dy; if2.obs1X = o1x; if2.obs1H = o1h; if2.obs2X = o2x; if2.obs2H = o2h; if2.x = px; if2.y = py;
    if3.dinoY = dy; if3.obs1X = o1x; if3.obs1H = o1h; if3.obs2X = o2x; if3.obs2H = o2h; if3.x = px; if3.y = py;
  endtask

  task automatic setFrame(input logic v);
    if0.frameClk = v; if1.frameClk = v; if2.frameClk = v; if3.frameClk = v;
  endtask

  function automatic logic [2:0] colorOf(input int unsigned s);
    case (s)
      0:       return if0.color;
      1:       return if1.color;
      2:       return if2.color;
      default: return if3.color;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulseFrames(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk); setFrame(1'b1);
      @(negedge clk); setFrame(1'b0);
    end
  endtask

  initial begin
    // name, screen, dinoY, obs1X, obs1H, obs2X, obs2H, x, y, expected
    vecs.push_back('{"rst_menu_bar",   0, 88, 200,   0, 200, 0,  70,  50, 3'b110});
    vecs.push_back('{"pause_dino",     1, 88, 200,   0, 200, 0,  12,  90, 3'b000});
    vecs.push_back('{"pause_bar",      1, 88, 200,   0, 200, 0,  70,  40, 3'b001});
    vecs.push_back('{"pause_bg",       1, 88, 200,   0, 200, 0,   5,   5, 3'b111});
    vecs.push_back('{"pause_offx",     1, 88, 200,   0, 200, 0, 160,   5, 3'b111});
    vecs.push_back('{"pause_offy",     1,115, 200,   0, 200, 0,  12, 120, 3'b111});
    vecs.push_back('{"over_tl",        2, 88, 200,   0, 200, 0,  60,  30, 3'b000});
    vecs.push_back('{"over_tr",        2, 88, 200,   0, 200, 0,  99,  30, 3'b000});
    vecs.push_back('{"over_panel",     2, 88, 200,   0, 200, 0,  70,  50, 3'b100});
    vecs.push_back('{"over_border",    2, 88, 200,   0, 200, 0,  40,  50, 3'b000});
    vecs.push_back('{"over_diag",      2, 88, 200,   0, 200, 0,  80,  50, 3'b000});
    vecs.push_back('{"over_anti",      2, 88, 200,   0, 200, 0,  79,  50, 3'b000});
    vecs.push_back('{"over_inner",     2, 88, 200,   0, 200, 0,  85,  50, 3'b100});
    vecs.push_back('{"obs_clip_in",    1, 88, 156,  10, 200, 0, 159,  95, 3'b000});
    vecs.push_back('{"obs_clip_left",  1, 88, 156,  10, 200, 0, 155,  95, 3'b111});
    vecs.push_back('{"obs_clip_off",   1, 88, 156,  10, 200, 0, 160,  95, 3'b111});
    vecs.push_back('{"obs2_h0",        1, 88, 200,   0,  30, 0,  32,  95, 3'b111});
    vecs.push_back('{"obs2_h1",        1, 88, 200,   0,  30, 1,  32,  99, 3'b000});
    vecs.push_back('{"obs2_h1_above",  1, 88, 200,   0,  30, 1,  32,  98, 3'b111});
    vecs.push_back('{"obs_tall",       1, 88,  20, 200, 200, 0,  22,   0, 3'b000});
    vecs.push_back('{"ground_top",     1, 88, 200,   0, 200, 0,  20, 100, 3'b000});
    vecs.push_back('{"ground_bot",     1, 88, 200,   0, 200, 0,  20, 101, 3'b000});
    vecs.push_back('{"below_ground",   1, 88, 200,   0, 200, 0,  20, 102, 3'b111});
    vecs.push_back('{"dino_edge_r",    1, 88, 200,   0, 200, 0,  19,  88, 3'b000});
    vecs.push_back('{"dino_out_r",     1, 88, 200,   0, 200, 0,  20,  88, 3'b111});
    vecs.push_back('{"dino_above",     1, 88, 200,   0, 200, 0,  12,  87, 3'b111});
    vecs.push_back('{"menu_dino",      0, 40, 200,   0, 200, 0,  12,  41, 3'b000});
    vecs.push_back('{"menu_hides_obs", 0, 88,  50,  80, 200, 0,  55,  50, 3'b110});
    vecs.push_back('{"menu_obs_out",   0, 88,  50,  80, 200, 0,  55,  80, 3'b000});
    vecs.push_back('{"scr3_menu",      3, 88, 200,   0, 200, 0,  70,  50, 3'b110});
    vecs.push_back('{"scr3_border",    3, 88, 200,   0, 200, 0,  40,  50, 3'b000});
    vecs.push_back('{"pause_nopanel",  1, 88, 200,   0, 200, 0,  40,  50, 3'b111});

    resetn = 1'b0;
    setFrame(1'b0);
    setIn(88, 200, 0, 200, 0, 70, 50);
    #12;
    @(negedge clk) resetn = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      setIn(vecs[i].dy, vecs[i].o1x, vecs[i].o1h, vecs[i].o2x, vecs[i].o2h, vecs[i].px, vecs[i].py);
      #1 check(vecs[i].name, {5'd0, colorOf(vecs[i].scr)}, {5'd0, vecs[i].exp});
    end

    // Blink and wrap of the frame counter
    @(negedge clk) setIn(88, 200, 0, 200, 0, 70, 50);
    #1 check("cnt_after_reset", dut0.frameCnt, 8'd0);
    pulseFrames(16);
    #1 check("blink_on16", {5'd0, colorOf(0)}, 8'h00);
    check("over_blink16", {5'd0, colorOf(2)}, 8'h04);
    pulseFrames(16);
    #1 check("blink_off32", {5'd0, colorOf(0)}, 8'h06);
    for (int unsigned f = 32; f < 100; f++) begin
      pulseFrames(1);
      #1 check("over_steady", {5'd0, colorOf(2)}, 8'h04);
    end
    pulseFrames(155);
    #1 check("cnt255_bar", {5'd0, colorOf(0)}, 8'h00);
    pulseFrames(1);
    #1 check("wrap_cnt", dut0.frameCnt, 8'd0);
    check("wrap_bar", {5'd0, colorOf(0)}, 8'h06);

    // Asynchronous reset in the middle of a frame
    pulseFrames(20);
    #1 check("pre_reset_bar", {5'd0, colorOf(0)}, 8'h00);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1 check("rst_async_cnt", dut0.frameCnt, 8'd0);
    check("rst_async_bar", {5'd0, colorOf(0)}, 8'h06);
    setIn(88, 200, 0, 200, 0, 70, 40);
    #1 check("rst_comb", {5'd0, colorOf(1)}, 8'h01);
    pulseFrames(3);
    #1 check("rst_ignore_frame", dut0.frameCnt, 8'd0);
    @(negedge clk) resetn = 1'b1;
    #1 check("release_cnt", dut0.frameCnt, 8'd0);
    pulseFrames(1);
    #1 check("resume_first", dut0.frameCnt, 8'd1);
    setIn(88, 200, 0, 200, 0, 70, 50);
    pulseFrames(15);
    #1 check("resume_blink", {5'd0, colorOf(0)}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
